// File: rtl/cart_dl_pkg.sv
// Shared types and constants for the cartridge / SG-1000 download controller.
package cart_dl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } dl_state_e;

    // Width of the address field stored per buffered byte.
    localparam int DL_ADDR_W = 25;

    // SG-1000 expansion RAM window: 8KB page 1, i.e. 0x2000-0x3FFF.
    localparam int EXTRAM_BASE_PAGE = 1;
    localparam int EXTRAM_LAST_ADDR = 32'h0000_3FFF;

    typedef struct packed {
        logic [DL_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } fifo_entry_t;

endpackage

// File: rtl/cart_download_ctrl_if.sv
// HPS ioctl byte stream plus SDRAM write port, as seen by the download controller.
interface cart_download_ctrl_if #(
    parameter int ADDR_W = 25
);
    logic              ioctl_download_i;
    logic [7:0]        ioctl_index_i;
    logic              ioctl_wr_i;
    logic [ADDR_W-1:0] ioctl_addr_i;
    logic [7:0]        ioctl_dout_i;
    logic              ioctl_wait_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_din_o;
    logic              mem_ack_i;

    modport slave (
        input  ioctl_download_i,
        input  ioctl_index_i,
        input  ioctl_wr_i,
        input  ioctl_addr_i,
        input  ioctl_dout_i,
        output ioctl_wait_o,
        output mem_req_o,
        output mem_addr_o,
        output mem_din_o,
        input  mem_ack_i
    );

    modport master (
        output ioctl_download_i,
        output ioctl_index_i,
        output ioctl_wr_i,
        output ioctl_addr_i,
        output ioctl_dout_i,
        input  ioctl_wait_o,
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_din_o,
        output mem_ack_i
    );

endinterface

// File: rtl/cart_dl_fifo.sv
// Write buffer between the ioctl stream and the SDRAM port; the head entry is
// visible without a read strobe so it can drive the write request directly.
module cart_dl_fifo
    import cart_dl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  fifo_entry_t      din,
    output fifo_entry_t      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; no reset needed because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/cart_download_ctrl.sv
// Cartridge / SG-1000 download controller: buffers ioctl bytes into SDRAM writes,
// derives image metadata and keeps the console in reset until the load settles.
module cart_download_ctrl
    import cart_dl_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int SG_INDEX    = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    cart_download_ctrl_if.slave bus,
    output logic [5:0]          cart_pages_o,
    output logic                sg1000_o,
    output logic                extram_o,
    output logic                console_reset_n_o,
    output logic                overflow_o
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int HOLD_W   = $clog2(HOLD_CYCLES) + 1;
    localparam int REGION_W = ADDR_W - 13;

    dl_state_e         state_r;
    dl_state_e         state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              mem_req_r;
    logic              mem_req_s;
    logic              console_rst_n_r;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;
    fifo_entry_t       entry_s;
    fifo_entry_t       head_s;
    logic              push_req_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              load_to_drain_s;
    logic              addr_zero_s;
    logic              in_region_s;
    logic              is_last_s;
    logic              sg_match_s;
    logic              all_ones_s;
    logic [5:0]        page_s;
    logic [5:0]        page_base_s;
    logic [5:0]        cart_pages_r;
    logic [5:0]        cart_pages_s;
    logic              sg1000_r;
    logic              sg1000_s;
    logic              cand_r;
    logic              cand_s;
    logic              seen_last_r;
    logic              seen_last_s;
    logic              extram_r;
    logic              extram_hold_s;
    logic              extram_s;
    logic              overflow_r;
    logic              overflow_s;
    logic              unused_index_s;

    assign push_req_s      = bus.ioctl_wr_i && (state_r == LOAD);
    assign push_ok_s       = push_req_s && !full_s;
    assign pop_s           = bus.mem_ack_i && mem_req_r;
    assign entry_s.addr    = DL_ADDR_W'(bus.ioctl_addr_i);
    assign entry_s.data    = bus.ioctl_dout_i;
    assign load_to_drain_s = (state_r == LOAD) && (state_s == DRAIN);

    assign addr_zero_s    = (bus.ioctl_addr_i == {ADDR_W{1'b0}});
    assign in_region_s    = (bus.ioctl_addr_i[ADDR_W-1:13] == REGION_W'(EXTRAM_BASE_PAGE));
    assign is_last_s      = (bus.ioctl_addr_i == ADDR_W'(EXTRAM_LAST_ADDR));
    assign sg_match_s     = (bus.ioctl_index_i[4:0] == 5'(SG_INDEX));
    assign all_ones_s     = &bus.ioctl_dout_i;
    assign page_s         = bus.ioctl_addr_i[19:14];
    assign unused_index_s = &{1'b0, bus.ioctl_index_i[7:5]};

    // The request stays up while any entry will remain after this edge.
    assign mem_req_s = push_ok_s
                    || (count_s > CNT_W'(1))
                    || ((count_s == CNT_W'(1)) && !pop_s);

    cart_dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .push  (push_ok_s),
        .pop   (pop_s),
        .din   (entry_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Download sequencing: load, drain the buffer, settle, release the console.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:  state_s = bus.ioctl_download_i ? LOAD : IDLE;
            LOAD:  state_s = bus.ioctl_download_i ? LOAD : DRAIN;
            DRAIN: begin
                if (bus.ioctl_download_i) begin
                    state_s = LOAD;
                end else if (empty_s && !mem_req_r) begin
                    state_s = HOLD;
                end else begin
                    state_s = DRAIN;
                end
            end
            HOLD: begin
                if (bus.ioctl_download_i) begin
                    state_s = LOAD;
                end else if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Metadata next-state: only accepted pushes update it; a drop only flags overflow.
    always_comb begin
        cart_pages_s  = cart_pages_r;
        sg1000_s      = sg1000_r;
        cand_s        = cand_r;
        seen_last_s   = seen_last_r;
        overflow_s    = overflow_r;
        extram_hold_s = extram_r;
        page_base_s   = cart_pages_r;
        if (push_ok_s) begin
            page_base_s   = addr_zero_s ? 6'd0 : cart_pages_r;
            cart_pages_s  = (page_s > page_base_s) ? page_s : page_base_s;
            sg1000_s      = addr_zero_s ? sg_match_s : sg1000_r;
            overflow_s    = addr_zero_s ? 1'b0 : overflow_r;
            extram_hold_s = addr_zero_s ? 1'b0 : extram_r;
            if (sg1000_r && in_region_s) begin
                cand_s      = (bus.ioctl_addr_i[12:0] == 13'd0) ? all_ones_s
                                                                : (cand_r & all_ones_s);
                seen_last_s = seen_last_r | is_last_s;
            end else begin
                cand_s      = addr_zero_s ? 1'b0 : cand_r;
                seen_last_s = addr_zero_s ? 1'b0 : seen_last_r;
            end
        end else begin
            overflow_s = overflow_r | push_req_s;
        end
    end

    assign extram_s = load_to_drain_s ? (cand_s & seen_last_s) : extram_hold_s;

    // Control registers: state, settle counter, write request, console reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r         <= IDLE;
            hold_cnt_r      <= {HOLD_W{1'b0}};
            mem_req_r       <= 1'b0;
            console_rst_n_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            hold_cnt_r      <= ((state_r == HOLD) && (state_s == HOLD))
                               ? hold_cnt_r + HOLD_W'(1) : {HOLD_W{1'b0}};
            mem_req_r       <= mem_req_s;
            console_rst_n_r <= (state_r == IDLE);
        end
    end

    // Metadata registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cart_pages_r <= 6'd0;
            sg1000_r     <= 1'b0;
            cand_r       <= 1'b0;
            seen_last_r  <= 1'b0;
            extram_r     <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            cart_pages_r <= cart_pages_s;
            sg1000_r     <= sg1000_s;
            cand_r       <= cand_s;
            seen_last_r  <= seen_last_s;
            extram_r     <= extram_s;
            overflow_r   <= overflow_s;
        end
    end

    assign bus.mem_req_o     = mem_req_r;
    assign bus.mem_addr_o    = ADDR_W'(head_s.addr);
    assign bus.mem_din_o     = head_s.data;
    assign bus.ioctl_wait_o  = (count_s >= CNT_W'(FIFO_DEPTH - 1));
    assign cart_pages_o      = cart_pages_r;
    assign sg1000_o          = sg1000_r;
    assign extram_o          = extram_r;
    assign console_reset_n_o = console_rst_n_r;
    assign overflow_o        = overflow_r;

endmodule

// File: tb/tb_cart_download_ctrl.sv
// Directed bench for cart_download_ctrl: an SDRAM responder logs every accepted
// write, and each scenario task checks outputs against hand-derived values.
module tb_cart_download_ctrl;
    localparam int ADDR_W      = 25;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_CYCLES = 16;
    localparam int SG_INDEX    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        cart_pages;
    logic              sg1000;
    logic              extram;
    logic              console_rst_n;
    logic              overflow;
    logic              ack_en = 1'b0;
    int                tests = 0;
    int                fails = 0;
    logic [ADDR_W-1:0] got_addr [$];
    logic [7:0]        got_data [$];

    cart_download_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cart_download_ctrl #(
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .SG_INDEX    (SG_INDEX)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (rst_n),
        .bus               (bus.slave),
        .cart_pages_o      (cart_pages),
        .sg1000_o          (sg1000),
        .extram_o          (extram),
        .console_reset_n_o (console_rst_n),
        .overflow_o        (overflow)
    );

    always #5 clk = ~clk;

    // SDRAM model: acks every pending request and logs the write it accepts.
    initial begin
        bus.mem_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && bus.mem_req_o) begin
                bus.mem_ack_i = 1'b1;
                got_addr.push_back(bus.mem_addr_o);
                got_data.push_back(bus.mem_din_o);
            end else begin
                bus.mem_ack_i = 1'b0;
            end
        end
    end

    task automatic put(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit obey_wait);
        int n = 0;
        while (obey_wait && bus.ioctl_wait_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL put_wait: ioctl_wait_o still 1 at addr %h, required 0", a);
        end
        bus.ioctl_addr_i = a;
        bus.ioctl_dout_i = d;
        bus.ioctl_wr_i   = 1'b1;
        @(negedge clk);
        bus.ioctl_wr_i   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index_i    = idx;
        bus.ioctl_download_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (bus.mem_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL drain_timeout: mem_req_o still 1, required 0");
        end
    endtask

    // Cycles from the drained point until console_reset_n_o is seen high.
    task automatic cycles_to_console(output int k);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (console_rst_n) break;
        end
    endtask

    task automatic test_reset();
        rst_n                = 1'b0;
        bus.ioctl_download_i = 1'b0;
        bus.ioctl_index_i    = 8'd0;
        bus.ioctl_wr_i       = 1'b0;
        bus.ioctl_addr_i     = {ADDR_W{1'b0}};
        bus.ioctl_dout_i     = 8'd0;
        #12;
        tests++;
        if ({bus.mem_req_o, bus.ioctl_wait_o, cart_pages, sg1000, extram, console_rst_n, overflow} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b wait=%b pages=%0d sg=%b ext=%b con=%b ovf=%b, required all 0",
                     bus.mem_req_o, bus.ioctl_wait_o, cart_pages, sg1000, extram, console_rst_n, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (console_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_console: got %b, required 1", console_rst_n);
        end
    endtask

    task automatic test_stream();
        int k;
        int bad = 0;
        ack_en = 1'b1;
        got_addr.delete();
        got_data.delete();
        start_dl(8'd0);
        for (int i = 0; i < 64; i++) put(ADDR_W'(i), 8'(i * 3 + 5), 1'b1);
        bus.ioctl_download_i = 1'b0;
        wait_drain();
        tests++;
        if (console_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL stream_console_during_load: got %b, required 0", console_rst_n);
        end
        // One cycle DRAIN->HOLD, HOLD_CYCLES in HOLD, one more for the registered output.
        cycles_to_console(k);
        tests++;
        if (k !== HOLD_CYCLES + 2) begin
            fails++;
            $display("FAIL stream_console_release: got %0d cycles, required %0d", k, HOLD_CYCLES + 2);
        end
        tests++;
        if (got_addr.size() !== 64) begin
            fails++;
            $display("FAIL stream_count: got %0d writes, required 64", got_addr.size());
        end
        for (int i = 0; i < got_addr.size(); i++)
            if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== 8'(i * 3 + 5)) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stream_order: got %0d wrong writes, required 0", bad);
        end
        tests++;
        if (cart_pages !== 6'd0) begin
            fails++;
            $display("FAIL stream_pages: got %0d, required 0", cart_pages);
        end
    endtask

    task automatic test_overflow();
        int k;
        int bad = 0;
        ack_en = 1'b0;
        got_addr.delete();
        got_data.delete();
        start_dl(8'd0);
        put(25'd0, 8'hA0, 1'b1);
        put(25'd1, 8'hA1, 1'b1);
        tests++;
        if (bus.ioctl_wait_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_wait_at_2: got %b, required 0", bus.ioctl_wait_o);
        end
        put(25'd2, 8'hA2, 1'b1);
        tests++;
        if (bus.ioctl_wait_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_wait_at_3: got %b, required 1", bus.ioctl_wait_o);
        end
        put(25'd3, 8'hA3, 1'b0);
        tests++;
        if (overflow !== 1'b0 || bus.mem_din_o !== 8'hA0) begin
            fails++;
            $display("FAIL ovf_full: got ovf=%b head=%h, required ovf=0 head=a0", overflow, bus.mem_din_o);
        end
        put(25'd4, 8'hEE, 1'b0);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got %b, required 1", overflow);
        end
        ack_en = 1'b1;
        wait_drain();
        tests++;
        if (got_data.size() !== 4) begin
            fails++;
            $display("FAIL ovf_count: got %0d writes, required 4", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(8'hA0 + i)) bad++;
        tests++;
        if (bad !== 0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_data: got %0d wrong bytes ovf=%b, required 0 wrong ovf=1", bad, overflow);
        end
        bus.ioctl_download_i = 1'b0;
        wait_drain();
        cycles_to_console(k);
    endtask

    task automatic sg_load(input logic [7:0] bad_byte);
        start_dl(8'(SG_INDEX));
        put(25'd0, 8'h00, 1'b1);
        tests++;
        if (overflow !== 1'b0 || extram !== 1'b0) begin
            fails++;
            $display("FAIL sg_addr0_clear: got ovf=%b ext=%b, required 0 0", overflow, extram);
        end
        for (int i = 0; i < 256; i++) put(ADDR_W'(32'h2000 + i), 8'hFF, 1'b1);
        put(25'h2100, bad_byte, 1'b1);
        put(25'h3FFF, 8'hFF, 1'b1);
        bus.ioctl_download_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sg_extram_set();
        int k;
        ack_en = 1'b1;
        sg_load(8'hFF);
        tests++;
        if (sg1000 !== 1'b1 || extram !== 1'b1 || cart_pages !== 6'd0) begin
            fails++;
            $display("FAIL sg_set: got sg=%b ext=%b pages=%0d, required 1 1 0", sg1000, extram, cart_pages);
        end
        wait_drain();
        cycles_to_console(k);
    endtask

    task automatic test_sg_extram_clear();
        int k;
        ack_en = 1'b1;
        sg_load(8'hFE);
        wait_drain();
        cycles_to_console(k);
        tests++;
        if (sg1000 !== 1'b1 || extram !== 1'b0) begin
            fails++;
            $display("FAIL sg_clear: got sg=%b ext=%b, required 1 0", sg1000, extram);
        end
    endtask

    task automatic test_cart_pages();
        int k;
        ack_en = 1'b1;
        got_addr.delete();
        got_data.delete();
        start_dl(8'd0);
        put(25'h0, 8'h11, 1'b1);
        put(25'h4000, 8'h22, 1'b1);
        tests++;
        if (cart_pages !== 6'd1) begin
            fails++;
            $display("FAIL pages_4000: got %0d, required 1", cart_pages);
        end
        put(25'h1FFFF, 8'h33, 1'b1);
        put(25'h8000, 8'h44, 1'b1);
        put(25'h100000, 8'h55, 1'b1);
        tests++;
        if (cart_pages !== 6'd7) begin
            fails++;
            $display("FAIL pages_max_wrap: got %0d, required 7", cart_pages);
        end
        bus.ioctl_download_i = 1'b0;
        wait_drain();
        cycles_to_console(k);
        tests++;
        if (got_addr.size() !== 5 || got_addr[got_addr.size() - 1] !== 25'h100000) begin
            fails++;
            $display("FAIL pages_high_addr: got %0d writes last=%h, required 5 last=100000",
                     got_addr.size(), got_addr[got_addr.size() - 1]);
        end
        tests++;
        if (cart_pages !== 6'd7 || sg1000 !== 1'b0 || extram !== 1'b0) begin
            fails++;
            $display("FAIL pages_meta: got pages=%0d sg=%b ext=%b, required 7 0 0", cart_pages, sg1000, extram);
        end
    endtask

    task automatic test_hold_reload();
        int k;
        int ones = 0;
        int n = 0;
        ack_en = 1'b1;
        got_addr.delete();
        got_data.delete();
        start_dl(8'd0);
        put(25'd0, 8'h01, 1'b1);
        put(25'd1, 8'h02, 1'b1);
        bus.ioctl_download_i = 1'b0;
        wait_drain();
        repeat (4) begin
            @(negedge clk);
            if (console_rst_n !== 1'b0) ones++;
        end
        bus.ioctl_download_i = 1'b1;
        @(negedge clk);
        put(25'd2, 8'h03, 1'b1);
        if (console_rst_n !== 1'b0) ones++;
        put(25'd3, 8'h04, 1'b1);
        if (console_rst_n !== 1'b0) ones++;
        bus.ioctl_download_i = 1'b0;
        while (bus.mem_req_o && n < 100) begin
            @(negedge clk);
            n++;
            if (console_rst_n !== 1'b0) ones++;
        end
        tests++;
        if (ones !== 0) begin
            fails++;
            $display("FAIL reload_console_low: got %0d high samples, required 0", ones);
        end
        cycles_to_console(k);
        tests++;
        if (k !== HOLD_CYCLES + 2) begin
            fails++;
            $display("FAIL reload_release: got %0d cycles, required %0d", k, HOLD_CYCLES + 2);
        end
        tests++;
        if (got_data.size() !== 4) begin
            fails++;
            $display("FAIL reload_writes: got %0d, required 4", got_data.size());
        end
    endtask

    task automatic test_reset_mid_load();
        ack_en = 1'b0;
        start_dl(8'd0);
        put(25'h0, 8'h10, 1'b1);
        put(25'h4000, 8'h20, 1'b1);
        put(25'h8000, 8'h30, 1'b1);
        tests++;
        if (bus.ioctl_wait_o !== 1'b1 || bus.mem_req_o !== 1'b1 || cart_pages !== 6'd2) begin
            fails++;
            $display("FAIL midrst_before: got wait=%b req=%b pages=%0d, required 1 1 2",
                     bus.ioctl_wait_o, bus.mem_req_o, cart_pages);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.mem_req_o, bus.ioctl_wait_o, cart_pages, console_rst_n, sg1000, extram, overflow} !== 12'd0) begin
            fails++;
            $display("FAIL midrst_async: got req=%b wait=%b pages=%0d con=%b, required all 0",
                     bus.mem_req_o, bus.ioctl_wait_o, cart_pages, console_rst_n);
        end
        bus.ioctl_download_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (console_rst_n !== 1'b1 || bus.mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_release: got con=%b req=%b, required 1 0", console_rst_n, bus.mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_sg_extram_set();
        test_cart_pages();
        test_sg_extram_clear();
        test_hold_reload();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
